// File: rtl/uart_img_pkg.sv
// Shared types and default sizing for the UART image buffer controller.
package uart_img_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_IMG_BYTES = 65536;

    typedef enum logic [2:0] {
        RX_LOAD = 3'd0,
        IDLE    = 3'd1,
        TX_READ = 3'd2,
        TX_SEND = 3'd3,
        TX_WAIT = 3'd4
    } uart_img_state_t;

endpackage

// File: rtl/uart_img_addr_ctr.sv
// Loadable/clearable image pointer that saturates at IMG_BYTES-1 and flags it.
module uart_img_addr_ctr
    import uart_img_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int IMG_BYTES = DEF_IMG_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_BYTES - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= (ld_val > LAST) ? LAST : ld_val;
        end else if (inc && !tc) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/uart_image_ctrl.sv
// UART image buffer controller: loads an image from uart_rx into RAM, streams it back via uart_tx.
// Optional running checksum of loaded bytes when UART_IMG_CHECKSUM_EN is defined.
module uart_image_ctrl
    import uart_img_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IMG_BYTES = DEF_IMG_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_byte,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_byte,
    input  logic              tx_done,
    input  logic              load_req,
    input  logic              retrieve_start,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              write_done,
    output logic              retrieve_done,
    output logic              rx_drop,
    output logic [DATA_W-1:0] rx_checksum
);

    uart_img_state_t   state;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_tc;
    logic              rd_tc;
    logic              last_wr_p0;
    logic              rx_acc;
    logic              wr_clr;
    logic              rd_clr;
    logic              rd_inc;

    // Once the final byte is accepted, further strobes are drops until the FSM reaches IDLE.
    assign rx_acc = (state == RX_LOAD) && rx_valid && !last_wr_p0;
    assign wr_clr = (state == IDLE) && load_req && !retrieve_start;
    assign rd_clr = (state == IDLE) && retrieve_start;
    assign rd_inc = (state == TX_WAIT) && tx_done && !rd_tc;

    assign ram_addr = (state == IDLE) ? proc_addr : ram_addr_q;

    uart_img_addr_ctr #(.ADDR_W(ADDR_W), .IMG_BYTES(IMG_BYTES)) u_wr_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wr_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (rx_acc),
        .cnt    (wr_ptr),
        .tc     (wr_tc)
    );

    uart_img_addr_ctr #(.ADDR_W(ADDR_W), .IMG_BYTES(IMG_BYTES)) u_rd_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rd_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (rd_inc),
        .cnt    (rd_ptr),
        .tc     (rd_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RX_LOAD;
            ram_addr_q    <= '0;
            ram_wdata     <= '0;
            ram_we        <= 1'b0;
            tx_start      <= 1'b0;
            tx_byte       <= '0;
            write_done    <= 1'b0;
            retrieve_done <= 1'b0;
            rx_drop       <= 1'b0;
            last_wr_p0    <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            tx_start   <= 1'b0;
            last_wr_p0 <= 1'b0;
            case (state)
                RX_LOAD: begin
                    if (rx_acc) begin
                        ram_we     <= 1'b1;
                        ram_addr_q <= wr_ptr;
                        ram_wdata  <= rx_byte;
                        last_wr_p0 <= wr_tc;
                    end
                    if (last_wr_p0) begin
                        write_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                IDLE: begin
                    if (retrieve_start) begin
                        retrieve_done <= 1'b0;
                        ram_addr_q    <= '0;
                        state         <= TX_READ;
                    end else if (load_req) begin
                        write_done <= 1'b0;
                        rx_drop    <= 1'b0;
                        state      <= RX_LOAD;
                    end
                end
                TX_READ: state <= TX_SEND;
                TX_SEND: begin
                    tx_byte  <= ram_rdata;
                    tx_start <= 1'b1;
                    state    <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        if (rd_tc) begin
                            retrieve_done <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            ram_addr_q <= rd_ptr + ADDR_W'(1);
                            state      <= TX_READ;
                        end
                    end
                end
                default: state <= RX_LOAD;
            endcase
            // A discarded strobe outranks a same-cycle clear so the drop is never lost.
            if (rx_valid && !rx_acc) begin
                rx_drop <= 1'b1;
            end
        end
    end

`ifdef UART_IMG_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_checksum <= '0;
        end else if (wr_clr) begin
            rx_checksum <= '0;
        end else if (rx_acc) begin
            rx_checksum <= rx_checksum + rx_byte;
        end
    end
`else
    assign rx_checksum = '0;
`endif

endmodule

// File: tb/tb_uart_image_ctrl.sv
// Bench for uart_image_ctrl with a RAM model, a uart_tx model and an image-level reference.
module tb_uart_image_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NB = 4;

    logic          clk;
    logic          rst_n;
    logic          rx_valid;
    logic [DW-1:0] rx_byte;
    logic          tx_start;
    logic [DW-1:0] tx_byte;
    logic          tx_done;
    logic          load_req;
    logic          retrieve_start;
    logic [AW-1:0] proc_addr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic          write_done;
    logic          retrieve_done;
    logic          rx_drop;
    logic [DW-1:0] rx_checksum;

    uart_image_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IMG_BYTES(NB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_valid       (rx_valid),
        .rx_byte        (rx_byte),
        .tx_start       (tx_start),
        .tx_byte        (tx_byte),
        .tx_done        (tx_done),
        .load_req       (load_req),
        .retrieve_start (retrieve_start),
        .proc_addr      (proc_addr),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_rdata      (ram_rdata),
        .write_done     (write_done),
        .retrieve_done  (retrieve_done),
        .rx_drop        (rx_drop),
        .rx_checksum    (rx_checksum)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] img [NB];
    int            strobe_cyc [$];
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    int            wc_q [$];
    logic [DW-1:0] tx_q [$];
    int            tc_q [$];
    int            done_cyc_q [$];
    int            tx_unstable = 0;
    int            wd_rise_cyc = -1;
    logic          wd_prev = 1'b0;
    logic [DW-1:0] mem [256];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with one cycle of registered read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_wdata);
            wc_q.push_back(cyc);
        end
        if (tx_start === 1'b1) begin
            tx_q.push_back(tx_byte);
            tc_q.push_back(cyc);
        end
        if (write_done === 1'b1 && wd_prev !== 1'b1) wd_rise_cyc = cyc;
        wd_prev = write_done;
    end

    // uart_tx model: tx_done ten cycles after each tx_start
    initial begin
        logic [DW-1:0] held;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                held = tx_byte;
                repeat (10) begin
                    @(negedge clk);
                    if (tx_byte !== held) tx_unstable++;
                end
                tx_done = 1'b1;
                done_cyc_q.push_back(cyc);
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] exp_csum();
        logic [DW-1:0] s = '0;
`ifdef UART_IMG_CHECKSUM_EN
        for (int i = 0; i < NB; i++) s = s + img[i];
`endif
        return s;
    endfunction

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        tx_q.delete(); tc_q.delete(); done_cyc_q.delete();
        wd_rise_cyc = -1;
    endtask

    task automatic send_image(input bit b2b);
        strobe_cyc.delete();
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_byte  = img[i];
            strobe_cyc.push_back(cyc);
            if (!b2b) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_byte  = DW'($urandom);
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load_req();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_retrieve(input bit both, output int sc, output logic [AW-1:0] a1,
                                output logic rd1, output logic wd1, output bit ok);
        int k = 0;
        @(negedge clk);
        retrieve_start = 1'b1;
        load_req       = both;
        sc             = cyc;
        @(negedge clk);
        retrieve_start = 1'b0;
        load_req       = 1'b0;
        a1  = ram_addr;
        rd1 = retrieve_done;
        wd1 = write_done;
        while (retrieve_done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        ok = (retrieve_done === 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_start, ram_we, write_done, retrieve_done, rx_drop} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {tx_start, ram_we, write_done, retrieve_done, rx_drop});
        end
        n_tests++;
        if (tx_byte !== '0 || ram_wdata !== '0 || ram_addr !== '0 || rx_checksum !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got tx_byte %0h wdata %0h addr %0h csum %0h expected all 0",
                     tx_byte, ram_wdata, ram_addr, rx_checksum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_gaps();
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        clear_logs();
        send_image(1'b0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (wa_q.size() != NB) begin
            n_fail++;
            $display("FAIL gap_write_count: got %0d expected %0d", wa_q.size(), NB);
        end
        for (int i = 0; i < NB && i < wa_q.size(); i++) begin
            n_tests++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== img[i] || wc_q[i] !== strobe_cyc[i] + 1) begin
                n_fail++;
                $display("FAIL gap_write%0d: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                         i, wa_q[i], wd_q[i], wc_q[i], i, img[i], strobe_cyc[i] + 1);
            end
        end
        n_tests++;
        if (wd_rise_cyc !== strobe_cyc[NB-1] + 2 || write_done !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_write_done: got rise cyc %0d level %b expected cyc %0d level 1",
                     wd_rise_cyc, write_done, strobe_cyc[NB-1] + 2);
        end
        n_tests++;
        if (rx_checksum !== exp_csum()) begin
            n_fail++;
            $display("FAIL gap_checksum: got %0h expected %0h", rx_checksum, exp_csum());
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            proc_addr = AW'($urandom);
            #1;
            n_tests++;
            if (ram_addr !== proc_addr || ram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_proc_addr: got addr %0h we %b expected addr %0h we 0",
                         ram_addr, ram_we, proc_addr);
            end
        end
    endtask

    task automatic test_retrieve();
        int sc; logic [AW-1:0] a1; logic rd1; logic wd1; bit ok;
        clear_logs();
        tx_unstable = 0;
        run_retrieve(1'b0, sc, a1, rd1, wd1, ok);
        n_tests++;
        if (!ok || a1 !== '0 || rd1 !== 1'b0) begin
            n_fail++;
            $display("FAIL retrieve_basic: got done %b addr %0h rd_early %b expected done 1 addr 0 rd_early 0",
                     ok, a1, rd1);
        end
        n_tests++;
        if (tc_q.size() != NB || tc_q[0] !== sc + 3) begin
            n_fail++;
            $display("FAIL retrieve_first_start: got count %0d cyc %0d expected count %0d cyc %0d",
                     tc_q.size(), tc_q[0], NB, sc + 3);
        end
        for (int i = 0; i < NB && i < tx_q.size(); i++) begin
            n_tests++;
            if (tx_q[i] !== img[i] || (i > 0 && tc_q[i] !== done_cyc_q[i-1] + 3)) begin
                n_fail++;
                $display("FAIL retrieve_byte%0d: got %0h at cyc %0d expected %0h",
                         i, tx_q[i], tc_q[i], img[i]);
            end
        end
        n_tests++;
        if (tx_unstable !== 0) begin
            n_fail++;
            $display("FAIL tx_byte_stable: got %0d changes expected 0", tx_unstable);
        end
        proc_addr = AW'($urandom);
        #1;
        n_tests++;
        if (ram_addr !== proc_addr || retrieve_done !== 1'b1) begin
            n_fail++;
            $display("FAIL retrieve_idle: got addr %0h rdone %b expected addr %0h rdone 1",
                     ram_addr, retrieve_done, proc_addr);
        end
    endtask

    task automatic test_back_to_back();
        pulse_load_req();
        n_tests++;
        if (write_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_rearm: got write_done %b expected 0", write_done);
        end
        for (int i = 0; i < NB; i++) img[i] = DW'($urandom);
        clear_logs();
        send_image(1'b1);
        repeat (3) @(negedge clk);
        n_tests++;
        if (wa_q.size() != NB) begin
            n_fail++;
            $display("FAIL b2b_write_count: got %0d expected %0d", wa_q.size(), NB);
        end
        for (int i = 0; i < NB && i < wa_q.size(); i++) begin
            n_tests++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== img[i] || wc_q[i] !== strobe_cyc[0] + 1 + i) begin
                n_fail++;
                $display("FAIL b2b_write%0d: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                         i, wa_q[i], wd_q[i], wc_q[i], i, img[i], strobe_cyc[0] + 1 + i);
            end
        end
        n_tests++;
        if (wd_rise_cyc !== strobe_cyc[NB-1] + 2 || rx_checksum !== exp_csum() || rx_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: got rise %0d csum %0h drop %b expected rise %0d csum %0h drop 0",
                     wd_rise_cyc, rx_checksum, rx_drop, strobe_cyc[NB-1] + 2, exp_csum());
        end
    endtask

    task automatic test_drop();
        int n0; int k;
        n0 = wa_q.size();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = DW'($urandom);
        @(negedge clk);
        rx_valid = 1'b0;
        n_tests++;
        if (rx_drop !== 1'b1 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: got drop %b we %b expected drop 1 we 0", rx_drop, ram_we);
        end
        clear_logs();
        @(negedge clk);
        retrieve_start = 1'b1;
        @(negedge clk);
        retrieve_start = 1'b0;
        k = 0;
        while (tx_start !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        rx_valid = 1'b1;
        rx_byte  = DW'($urandom);
        @(negedge clk);
        rx_valid = 1'b0;
        n_tests++;
        if (k >= 20 || ram_we !== 1'b0 || rx_drop !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_tx_wait: got wait %0d we %b drop %b expected wait <20 we 0 drop 1",
                     k, ram_we, rx_drop);
        end
        k = 0;
        while (retrieve_done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (wa_q.size() != 0 || tx_q.size() != NB || tx_q[0] !== img[0] || tx_q[NB-1] !== img[NB-1]) begin
            n_fail++;
            $display("FAIL drop_stream: got writes %0d tx %0d first %0h last %0h expected 0 %0d %0h %0h",
                     wa_q.size(), tx_q.size(), tx_q[0], tx_q[NB-1], NB, img[0], img[NB-1]);
        end
        repeat (2) @(negedge clk);
        pulse_load_req();
        n_tests++;
        if (rx_drop !== 1'b0 || write_done !== 1'b0 || rx_checksum !== '0) begin
            n_fail++;
            $display("FAIL drop_clear: got drop %b wdone %b csum %0h expected 0 0 0",
                     rx_drop, write_done, rx_checksum);
        end
        for (int i = 0; i < NB; i++) img[i] = DW'($urandom);
        clear_logs();
        send_image(1'b0);
        repeat (3) @(negedge clk);
        n_tests++;
        if (wa_q.size() != NB || wa_q[0] !== '0 || wd_q[NB-1] !== img[NB-1] || write_done !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_reload: got writes %0d addr0 %0h last %0h wdone %b expected %0d 0 %0h 1",
                     wa_q.size(), wa_q[0], wd_q[NB-1], write_done, NB, img[NB-1]);
        end
    endtask

    task automatic test_both_req();
        int sc; logic [AW-1:0] a1; logic rd1; logic wd1; bit ok;
        clear_logs();
        run_retrieve(1'b1, sc, a1, rd1, wd1, ok);
        n_tests++;
        if (a1 !== '0 || wd1 !== 1'b1 || rd1 !== 1'b0 || !ok) begin
            n_fail++;
            $display("FAIL both_req_start: got addr %0h wdone %b rdone %b done %b expected 0 1 0 1",
                     a1, wd1, rd1, ok);
        end
        for (int i = 0; i < NB && i < tx_q.size(); i++) begin
            n_tests++;
            if (tx_q[i] !== img[i]) begin
                n_fail++;
                $display("FAIL both_req_byte%0d: got %0h expected %0h", i, tx_q[i], img[i]);
            end
        end
        n_tests++;
        if (tx_q.size() != NB || write_done !== 1'b1) begin
            n_fail++;
            $display("FAIL both_req_end: got tx %0d wdone %b expected %0d 1", tx_q.size(), write_done, NB);
        end
    endtask

    task automatic test_reset_midload();
        int sc; logic [AW-1:0] a1; logic rd1; logic wd1; bit ok;
        pulse_load_req();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_byte  = DW'($urandom_range(1, 255));
            @(negedge clk);
            rx_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({tx_start, ram_we, write_done, retrieve_done, rx_drop} !== 5'b0) begin
            n_fail++;
            $display("FAIL midload_reset_flags: got %b expected 00000",
                     {tx_start, ram_we, write_done, retrieve_done, rx_drop});
        end
        n_tests++;
        if (tx_byte !== '0 || ram_wdata !== '0 || ram_addr !== '0 || rx_checksum !== '0) begin
            n_fail++;
            $display("FAIL midload_reset_data: got tx_byte %0h wdata %0h addr %0h csum %0h expected all 0",
                     tx_byte, ram_wdata, ram_addr, rx_checksum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NB; i++) img[i] = DW'($urandom);
        clear_logs();
        send_image(1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NB && i < wa_q.size(); i++) begin
            n_tests++;
            if (wa_q[i] !== AW'(i) || wd_q[i] !== img[i]) begin
                n_fail++;
                $display("FAIL reload_write%0d: got addr %0h data %0h expected addr %0h data %0h",
                         i, wa_q[i], wd_q[i], i, img[i]);
            end
        end
        n_tests++;
        if (wa_q.size() != NB || write_done !== 1'b1 || rx_checksum !== exp_csum()) begin
            n_fail++;
            $display("FAIL reload_done: got writes %0d wdone %b csum %0h expected %0d 1 %0h",
                     wa_q.size(), write_done, rx_checksum, NB, exp_csum());
        end
        clear_logs();
        run_retrieve(1'b0, sc, a1, rd1, wd1, ok);
        n_tests++;
        if (!ok || tx_q.size() != NB || tx_q[0] !== img[0] || tx_q[NB-1] !== img[NB-1]) begin
            n_fail++;
            $display("FAIL reload_stream: got done %b tx %0d first %0h last %0h expected 1 %0d %0h %0h",
                     ok, tx_q.size(), tx_q[0], tx_q[NB-1], NB, img[0], img[NB-1]);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        rx_valid       = 1'b0;
        rx_byte        = '0;
        load_req       = 1'b0;
        retrieve_start = 1'b0;
        proc_addr      = '0;
        test_reset();
        test_load_gaps();
        test_retrieve();
        test_back_to_back();
        test_drop();
        test_both_req();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
